// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : shared UART baud-control types and constants
// Rev 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef logic [10:0] dvsr_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_FALL = 2'd1,
    ST_MEASURE   = 2'd2,
    ST_RESULT    = 2'd3
  } ab_state_t;

  localparam dvsr_t DVSR_MIN_DEF = 11'd2;
  localparam dvsr_t DVSR_RST_DEF = 11'd326;

endpackage
`default_nettype wire

// File: rtl/uart_sync_edge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_sync_edge : 2-flop synchroniser with falling/rising edge detect
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic fall,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Flops come out of reset high so an idle line never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign dout = r_sync;
  assign fall = r_prev & ~r_sync;
  assign rise = ~r_prev & r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_baud_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_baud_ctrl : idle-gated divisor staging plus auto-baud start-bit measure
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_baud_ctrl
  import uart_pkg::*;
#(
  parameter dvsr_t       DVSR_RST  = DVSR_RST_DEF,
  parameter int unsigned OVSR_LOG2 = 4,
  parameter dvsr_t       DVSR_MIN  = DVSR_MIN_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_wr,
  input  logic [10:0] cfg_dvsr,
  input  logic        ab_req,
  input  logic        tx_busy,
  input  logic        rx_busy,
  input  logic        rx_line,
  output logic [10:0] dvsr,
  output logic        cfg_pending,
  output logic        cfg_ack,
  output logic        cfg_rej,
  output logic        ab_busy,
  output logic        ab_done,
  output logic        ab_err
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_pre = c_cnt_max - CNT_W'(1);
  localparam logic [CNT_W-1:0] c_res_max = CNT_W'(2047);
  localparam logic [CNT_W-1:0] c_res_min = CNT_W'(DVSR_MIN);

  ab_state_t        r_state;
  ab_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  dvsr_t            r_stg;
  dvsr_t            r_dvsr;
  logic             r_pending;
  logic             r_ack;
  logic             r_rej;
  logic             r_done;
  logic             r_err;

  logic             w_line;
  logic             w_fall;
  logic             w_rise;
  logic             w_busy;
  logic             w_apply;
  logic             w_cfg_bad;
  logic             w_cfg_ok;
  logic             w_cnt_sat;
  logic [CNT_W-1:0] w_res;
  logic             w_res_ok;

  uart_sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (rx_line),
    .dout (w_line),
    .fall (w_fall),
    .rise (w_rise)
  );

  assign w_busy    = (r_state != ST_IDLE);
  assign w_apply   = r_pending & ~tx_busy & ~rx_busy;
  assign w_cfg_bad = cfg_wr & ((cfg_dvsr < DVSR_MIN) | w_busy);
  assign w_cfg_ok  = cfg_wr & ~w_cfg_bad;
  // Next increment lands on all-ones: stop there instead of wrapping.
  assign w_cnt_sat = ~w_line & (r_cnt == c_cnt_pre);
  assign w_res     = r_cnt >> OVSR_LOG2;
  assign w_res_ok  = ~r_ovf & (w_res <= c_res_max) & (w_res >= c_res_min);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (ab_req) w_state_nxt = ST_WAIT_FALL;
      ST_WAIT_FALL: if (w_fall) w_state_nxt = ST_MEASURE;
      ST_MEASURE:   if (w_rise || w_cnt_sat) w_state_nxt = ST_RESULT;
      ST_RESULT:    w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_stg     <= DVSR_RST;
      r_dvsr    <= DVSR_RST;
      r_pending <= 1'b0;
      r_ack     <= 1'b0;
      r_rej     <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ack  <= 1'b0;
      r_rej  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_apply) begin
        r_dvsr    <= r_stg;
        r_pending <= 1'b0;
        r_ack     <= 1'b1;
      end
      // A fresh write re-arms pending even if the old value applies this cycle.
      if (w_cfg_bad) begin
        r_rej <= 1'b1;
      end else if (w_cfg_ok) begin
        r_stg     <= cfg_dvsr;
        r_pending <= 1'b1;
      end
      case (r_state)
        ST_IDLE: if (ab_req) r_pending <= 1'b0;
        ST_WAIT_FALL: begin
          if (w_fall) begin
            r_cnt <= CNT_W'(1);
            r_ovf <= 1'b0;
          end
        end
        ST_MEASURE: begin
          if (!w_line) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_cnt_sat) r_ovf <= 1'b1;
          end
        end
        ST_RESULT: begin
          if (w_res_ok) begin
            r_stg     <= w_res[10:0];
            r_pending <= 1'b1;
            r_done    <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dvsr        = r_dvsr;
  assign cfg_pending = r_pending;
  assign cfg_ack     = r_ack;
  assign cfg_rej     = r_rej;
  assign ab_busy     = w_busy;
  assign ab_done     = r_done;
  assign ab_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_baud_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_uart_baud_ctrl : scoreboard bench for uart_baud_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_baud_ctrl;
  import uart_pkg::*;

  localparam int OVSR_LOG2 = 4;
  localparam int CNT_MAX   = 65535;
  localparam int RST_DVSR  = 326;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr;
  logic [10:0] cfg_dvsr;
  logic        ab_req;
  logic        tx_busy;
  logic        rx_busy;
  logic        rx_line;
  logic [10:0] dvsr;
  logic        cfg_pending;
  logic        cfg_ack;
  logic        cfg_rej;
  logic        ab_busy;
  logic        ab_done;
  logic        ab_err;

  always #5 clk = ~clk;

  uart_baud_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_wr      (cfg_wr),
    .cfg_dvsr    (cfg_dvsr),
    .ab_req      (ab_req),
    .tx_busy     (tx_busy),
    .rx_busy     (rx_busy),
    .rx_line     (rx_line),
    .dvsr        (dvsr),
    .cfg_pending (cfg_pending),
    .cfg_ack     (cfg_ack),
    .cfg_rej     (cfg_rej),
    .ab_busy     (ab_busy),
    .ab_done     (ab_done),
    .ab_err      (ab_err)
  );

  typedef enum int {EV_ACK, EV_REJ, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       value;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  m_dvsr  = RST_DVSR;

  function automatic void check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  function automatic void push(input ev_kind_t k, input int v);
    ev_t e;
    e.kind  = k;
    e.value = v;
    exp_q.push_back(e);
  endfunction

  task automatic expect_pop(input ev_kind_t k, input string nm);
    ev_t e;
    if (exp_q.size() == 0) begin
      check({"unexpected ", nm}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({nm, " event kind"}, int'(k), int'(e.kind));
      if (k == EV_ACK) check("dvsr at cfg_ack", int'(dvsr), e.value);
    end
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  bit          mon_armed = 1'b0;
  bit          mon_busy_q;
  logic [10:0] mon_dvsr_q;
  always @(negedge clk) begin
    if (!rst) begin
      if (cfg_rej) expect_pop(EV_REJ, "cfg_rej");
      if (ab_err)  expect_pop(EV_ERR, "ab_err");
      if (ab_done) expect_pop(EV_DONE, "ab_done");
      if (cfg_ack) expect_pop(EV_ACK, "cfg_ack");
      if (mon_armed && dvsr != mon_dvsr_q)
        check("dvsr changed while tx/rx busy", int'(mon_busy_q), 0);
      mon_armed = 1'b1;
    end else begin
      mon_armed = 1'b0;
    end
    mon_dvsr_q = dvsr;
    mon_busy_q = tx_busy | rx_busy;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    m_dvsr = RST_DVSR;
    tick(2);
  endtask

  task automatic cfg_write(input int v);
    cfg_dvsr = 11'(v);
    cfg_wr   = 1'b1;
    tick();
    cfg_wr   = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check({nm, " outstanding events"}, exp_q.size(), 0);
    exp_q.delete();
    tick(2);
  endtask

  // Expected divisor = low-time / 16, legal only within [DVSR_MIN, 2047] and below overflow.
  task automatic autobaud(input int width, input bit with_rej, input string nm);
    int res;
    bit ok;
    int n;
    res = width >> OVSR_LOG2;
    ok  = (width < CNT_MAX) && (res >= int'(DVSR_MIN_DEF)) && (res <= 2047);
    ab_req = 1'b1;
    tick();
    ab_req = 1'b0;
    check({nm, " ab_busy after req"}, int'(ab_busy), 1);
    if (with_rej) begin
      push(EV_REJ, 0);
      cfg_write(100);
    end
    tick(2);
    if (ok) begin
      push(EV_DONE, 0);
      push(EV_ACK, res);
    end else begin
      push(EV_ERR, 0);
    end
    rx_line = 1'b0;
    tick(width);
    rx_line = 1'b1;
    n = 0;
    while (ab_busy && n < 50) begin
      tick();
      n++;
    end
    check({nm, " ab_busy clears"}, int'(ab_busy), 0);
    if (ok) m_dvsr = res;
    drain(nm);
    check({nm, " dvsr"}, int'(dvsr), m_dvsr);
  endtask

  initial begin
    int v;
    int last;
    int k;
    rst = 1'b1; cfg_wr = 1'b0; cfg_dvsr = '0; ab_req = 1'b0;
    tx_busy = 1'b0; rx_busy = 1'b0; rx_line = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    check("reset dvsr", int'(dvsr), RST_DVSR);
    check("reset cfg_pending", int'(cfg_pending), 0);
    check("reset ab_busy", int'(ab_busy), 0);

    // Idle write: pending for exactly one cycle, then applied.
    push(EV_ACK, 27);
    cfg_write(27);
    check("idle write pending", int'(cfg_pending), 1);
    check("idle write dvsr before apply", int'(dvsr), RST_DVSR);
    tick();
    check("idle write pending cleared", int'(cfg_pending), 0);
    check("idle write dvsr applied", int'(dvsr), 27);
    m_dvsr = 27;
    drain("idle write");

    // Held off by tx_busy; last write wins, single ack.
    do_reset();
    tx_busy = 1'b1;
    tick();
    cfg_write(27);
    cfg_write(54);
    tick(100);
    check("busy hold dvsr", int'(dvsr), RST_DVSR);
    check("busy hold pending", int'(cfg_pending), 1);
    push(EV_ACK, 54);
    tx_busy = 1'b0;
    tick();
    check("busy release dvsr", int'(dvsr), 54);
    m_dvsr = 54;
    drain("busy release");

    push(EV_REJ, 0);
    cfg_write(1);
    push(EV_REJ, 0);
    cfg_write(0);
    drain("below-min write");
    check("below-min dvsr", int'(dvsr), m_dvsr);

    autobaud(5200, 1'b1, "ab 5200");
    autobaud(20, 1'b0, "ab 20");
    autobaud(31, 1'b0, "ab 31");
    autobaud(32, 1'b0, "ab 32");
    autobaud(CNT_MAX + 5, 1'b0, "ab overflow");

    // Reset while measuring.
    ab_req = 1'b1;
    tick();
    ab_req = 1'b0;
    tick(2);
    rx_line = 1'b0;
    tick(200);
    #2 rst = 1'b1;
    #1;
    check("mid-measure reset dvsr", int'(dvsr), RST_DVSR);
    check("mid-measure reset ab_busy", int'(ab_busy), 0);
    check("mid-measure reset pending", int'(cfg_pending), 0);
    rx_line = 1'b1;
    tick(2);
    rst = 1'b0;
    m_dvsr = RST_DVSR;
    tick(4);

    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          v = $urandom_range(0, 2047);
          if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 3);
          if (v < int'(DVSR_MIN_DEF)) begin
            push(EV_REJ, 0);
          end else begin
            push(EV_ACK, v);
            m_dvsr = v;
          end
          cfg_write(v);
          drain("rand idle write");
          check("rand idle write dvsr", int'(dvsr), m_dvsr);
        end
        1: begin
          if ($urandom_range(0, 1) == 0) tx_busy = 1'b1;
          else                           rx_busy = 1'b1;
          tick();
          last = 0;
          k = $urandom_range(1, 3);
          for (int w = 0; w < k; w++) begin
            last = $urandom_range(2, 2047);
            cfg_write(last);
          end
          tick($urandom_range(5, 30));
          check("rand busy hold dvsr", int'(dvsr), m_dvsr);
          push(EV_ACK, last);
          m_dvsr = last;
          tx_busy = 1'b0;
          rx_busy = 1'b0;
          drain("rand busy write");
          check("rand busy write dvsr", int'(dvsr), m_dvsr);
        end
        default: begin
          autobaud($urandom_range(16, 400), 1'($urandom_range(0, 1)), "rand ab");
        end
      endcase
    end

    check("final queue empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_baud_ctrl.md
Name: uart_baud_ctrl

Overview:
Configuration controller for the UART baud-tick generator. It owns the 11-bit divisor `dvsr` consumed by the baud generator and applies new divisors in two ways:
- software writes, applied only while both TX and RX are idle, so a frame is never corrupted mid-bit;
- an auto-baud measurement of the RX start-bit width.

It sits between the register/CSR interface and the baud generator, in front of the TX/RX datapaths.

Parameters:
- DVSR_RST, 11'd326: divisor loaded at reset (50 MHz, 9600 baud, x16).
- OVSR_LOG2, 4: log2 of RX oversampling. The auto-baud divisor is the measured cycles >> OVSR_LOG2.
- DVSR_MIN, 11'd2: smallest legal divisor. Below it the result is an error.
- CNT_W, 16: width of the auto-baud cycle counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cfg_wr  in  1  one-cycle request to stage cfg_dvsr
- cfg_dvsr  in  11  requested divisor
- ab_req  in  1  one-cycle request to start auto-baud
- tx_busy  in  1  transmitter mid-frame
- rx_busy  in  1  receiver mid-frame
- rx_line  in  1  raw asynchronous RX serial input
- dvsr  out  11  active divisor to the baud generator
- cfg_pending  out  1  staged divisor waiting for idle
- cfg_ack  out  1  one-cycle pulse when the staged divisor becomes active
- cfg_rej  out  1  one-cycle pulse: cfg_wr rejected
- ab_busy  out  1  auto-baud in progress
- ab_done  out  1  one-cycle pulse: auto-baud succeeded
- ab_err  out  1  one-cycle pulse: auto-baud failed

Behaviour:
- Reset values:
  - dvsr = DVSR_RST.
  - All pulses, cfg_pending and ab_busy = 0.
  - FSM = IDLE, counter = 0.
  - Synchroniser flops = 1 (line idle).
- rx_line passes through a 2-flop synchroniser plus one history flop.
  - Falling edge = (prev == 1 && cur == 0).
  - Edge detection therefore lags the pin by 2–3 cycles. The measured width is unaffected.
- Staging register stg (11 bits) and flag cfg_pending.
  - Apply condition: cfg_pending && !tx_busy && !rx_busy.
  - When it holds: dvsr <= stg, cfg_pending <= 0, cfg_ack = 1 in the next cycle.
- cfg_wr handling:
  - cfg_wr with cfg_dvsr < DVSR_MIN, or while ab_busy: cfg_rej pulse, no state change.
  - Otherwise: stg <= cfg_dvsr, cfg_pending <= 1. A later cfg_wr overwrites a still-pending value (last write wins).
  - cfg_wr in the same cycle the apply condition holds: the old stg is applied, the new value is staged, and cfg_pending stays 1.
- FSM states: IDLE, WAIT_FALL, MEASURE, RESULT.
  - IDLE: on ab_req go to WAIT_FALL with ab_busy = 1. A pending cfg write is cancelled (cfg_pending <= 0, no ack).
  - WAIT_FALL: on a falling edge, counter <= 1 and go to MEASURE. ab_req is ignored while busy.
  - MEASURE: counter increments each cycle the synchronised line is 0. On the synchronised line returning to 1, go to RESULT.
    - If the counter reaches its all-ones value, go to RESULT with an overflow flag set. The counter saturates and does not wrap.
  - RESULT (one cycle):
    - res = counter >> OVSR_LOG2.
    - If overflow, or res > 2047, or res < DVSR_MIN: ab_err pulse, dvsr unchanged.
    - Otherwise: stg <= res[10:0], cfg_pending <= 1, ab_done pulse. The value applies via the normal idle rule.
    - Then go to IDLE and clear ab_busy.
- ab_busy stays 1 from the cycle after ab_req through RESULT.
- dvsr changes only on the apply condition. It never changes while tx_busy or rx_busy is 1.
- Reset asserted mid-operation: immediate return to reset values. The staged value is lost.

Decomposition:
- Package uart_pkg holds:
  - typedef dvsr_t = logic [10:0];
  - the FSM enum ab_state_t;
  - DVSR_MIN_DEF and DVSR_RST_DEF constants, shared with the baud generator and TB.
- One sub-module: uart_sync_edge (2-flop synchroniser plus falling/rising edge detector). It is reusable by the RX block.

Test Plan:
- Reset only → dvsr = 326, cfg_pending = 0, ab_busy = 0.
- cfg_wr with cfg_dvsr = 27, TX and RX idle → cfg_pending = 1 for exactly one cycle, then dvsr = 27 and one cfg_ack pulse.
- tx_busy = 1, cfg_wr 27, then cfg_wr 54, then tx_busy drops after 100 cycles → dvsr remains 326 until the drop, then becomes 54. Exactly one cfg_ack.
- ab_req, then rx_line low for 5200 cycles then high, all idle → ab_done, dvsr = 325 (5200 >> 4).
- ab_req, then rx_line low for 20 cycles → res = 1 < 2, so ab_err pulses and dvsr is unchanged. Also rx_line held low for 65535+ cycles → ab_err via overflow.
- Two mid-operation cases:
  - cfg_wr during ab_busy → cfg_rej pulse.
  - rst asserted during MEASURE → dvsr = 326, ab_busy = 0 immediately.
